// File: rtl/sseg_spi_rx.sv
// Display-link frame receiver: oversamples sclk/sdo/ss on clk_i, deserializes one
// WIDTH-bit frame per ss-low window and presents it on a valid/ready output.
//
// state     | meaning
// WAIT_IDLE | after reset: ignore everything until the synced ss is seen high
// IDLE      | between frames, waiting for ss to fall
// SHIFT     | ss low: shift sdo in on each sclk rising edge
// DELIVER   | ss has risen: check length, then present, drop or flag the frame
module sseg_spi_rx #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic             sdo_i,
    input  logic             ss_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic             err_o,
    output logic             ovf_o
);

    localparam int CNT_W   = $clog2(WIDTH + 2);
    localparam int FLUSH   = SYNC_STAGES + 2;
    localparam int FLUSH_W = $clog2(FLUSH + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LD = FLUSH_W'(FLUSH);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        DELIVER
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdo_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_s;
    logic                   sdo_s;
    logic                   ss_s;
    logic                   sclk_d1_q;
    logic                   ss_d1_q;

    logic                   sclk_rise_q;
    logic                   ss_rise_q;
    logic                   ss_fall_q;
    logic                   ss_lvl_q;
    logic                   sdo_q;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   vld_q, vld_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdo_s  = sdo_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    // Synchronizers and edge detect; the edge pulses are registered together with
    // the matching sdo/ss levels so the FSM sees one aligned snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            sdo_sync_q  <= '0;
            ss_sync_q   <= '1;
            sclk_d1_q   <= 1'b0;
            ss_d1_q     <= 1'b1;
            sclk_rise_q <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_lvl_q    <= 1'b1;
            sdo_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], sdo_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            sclk_d1_q   <= sclk_s;
            ss_d1_q     <= ss_s;
            sclk_rise_q <= sclk_s & ~sclk_d1_q;
            ss_rise_q   <= ss_s & ~ss_d1_q;
            ss_fall_q   <= ~ss_s & ss_d1_q;
            ss_lvl_q    <= ss_s;
            sdo_q       <= sdo_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            flush_q <= FLUSH_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = vld_q & ~rdy_i;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        flush_d = flush_q;
        if (flush_q != '0) begin
            flush_d = flush_q - 1'b1;
        end

        case (state_q)
            // The synchronizers reload the idle level on reset, so the synced ss is
            // only trusted once the flush timer has let the real pin value through.
            WAIT_IDLE: begin
                if ((flush_q == '0) && ss_lvl_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (ss_rise_q) begin
                    state_d = DELIVER;
                end else if (sclk_rise_q && !ss_lvl_q) begin
                    shift_d = {shift_q[WIDTH-2:0], sdo_q};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DELIVER: begin
                state_d = IDLE;
                if (cnt_q != CNT_FULL) begin
                    err_d = 1'b1;
                end else if (!vld_q || rdy_i) begin
                    data_d = shift_q;
                    vld_d  = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                if (ss_fall_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_sseg_spi_rx.sv
// Directed bench for sseg_spi_rx: bit-banged frames with hand-computed expectations.
module tb_sseg_spi_rx;

    logic        clk_i  = 1'b0;
    logic        rst_i  = 1'b1;
    logic        sclk_i = 1'b0;
    logic        sdo_i  = 1'b0;
    logic        ss_i   = 1'b1;
    logic        rdy_i  = 1'b0;
    logic [63:0] data_o;
    logic        vld_o;
    logic        err_o;
    logic        ovf_o;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_errp = 0;
    int n_ovfp = 0;
    int n_vld  = 0;
    int e0, o0, v0;

    sseg_spi_rx #(
        .WIDTH(64),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sclk_i(sclk_i),
        .sdo_i (sdo_i),
        .ss_i  (ss_i),
        .data_o(data_o),
        .vld_o (vld_o),
        .rdy_i (rdy_i),
        .err_o (err_o),
        .ovf_o (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (err_o) n_errp++;
        if (ovf_o) n_ovfp++;
        if (vld_o) n_vld++;
        chk("err_ovf_excl", 64'(err_o & ovf_o), 64'd0);
    endtask

    task automatic shift_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdo_i = v[i];
            repeat (4) tick();
            sclk_i = 1'b1;
            repeat (4) tick();
            sclk_i = 1'b0;
        end
    endtask

    task automatic frame_body(input logic [127:0] v, input int n);
        ss_i = 1'b0;
        repeat (4) tick();
        shift_bits(v, n);
        repeat (4) tick();
    endtask

    task automatic send_frame(input logic [127:0] v, input int n);
        frame_body(v, n);
        ss_i = 1'b1;
        repeat (8) tick();
    endtask

    // vld must rise on the 5th sampled edge after ss goes high (2 sync + 2 pipeline
    // cycles after the first edge that sees the pin high).
    task automatic expect_frame(input string tag, input logic [63:0] exp);
        frame_body({64'h0, exp}, 64);
        ss_i = 1'b1;
        repeat (4) tick();
        chk({tag, "_vld_early"}, 64'(vld_o), 64'd0);
        tick();
        chk({tag, "_vld"}, 64'(vld_o), 64'd1);
        chk({tag, "_data"}, data_o, exp);
        repeat (3) tick();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_data", data_o, 64'd0);
        chk("rst_vld", 64'(vld_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        rst_i = 1'b0;
        repeat (8) tick();

        // 1: single frame, rdy high -> one-cycle vld at the expected latency
        rdy_i = 1'b1;
        e0 = n_errp; o0 = n_ovfp;
        expect_frame("t1", 64'hdeadbeefbeefface);
        chk("t1_vld_pulse", 64'(vld_o), 64'd0);
        chk("t1_err", 64'(n_errp - e0), 64'd0);
        chk("t1_ovf", 64'(n_ovfp - o0), 64'd0);

        // 2: output held, second frame dropped with one ovf pulse
        rdy_i = 1'b0;
        e0 = n_errp;
        send_frame({64'h0, 64'h0123456789abcdef}, 64);
        chk("t2_vld1", 64'(vld_o), 64'd1);
        chk("t2_data1", data_o, 64'h0123456789abcdef);
        o0 = n_ovfp;
        send_frame({64'h0, 64'hffffffff00000000}, 64);
        chk("t2_ovf", 64'(n_ovfp - o0), 64'd1);
        chk("t2_err", 64'(n_errp - e0), 64'd0);
        chk("t2_vld_held", 64'(vld_o), 64'd1);
        chk("t2_data_held", data_o, 64'h0123456789abcdef);
        rdy_i = 1'b1;
        tick();
        chk("t2_vld_clr", 64'(vld_o), 64'd0);

        // 3: 10-bit, 65-bit and empty frames all flag err
        e0 = n_errp; v0 = n_vld;
        send_frame({118'h0, 10'h2a5}, 10);
        send_frame({63'h0, 65'h1_5555_5555_5555_5555}, 65);
        ss_i = 1'b0;
        repeat (4) tick();
        ss_i = 1'b1;
        repeat (8) tick();
        chk("t3_err_cnt", 64'(n_errp - e0), 64'd3);
        chk("t3_no_vld", 64'(n_vld - v0), 64'd0);
        chk("t3_data", data_o, 64'h0123456789abcdef);

        // 4: reset mid-frame; remainder of that frame must be ignored
        ss_i = 1'b0;
        repeat (4) tick();
        shift_bits({64'h0, 64'h0f0f1234abcd9876} >> 34, 30);
        rst_i = 1'b1;
        tick();
        chk("t4_rst_data", data_o, 64'd0);
        chk("t4_rst_vld", 64'(vld_o), 64'd0);
        chk("t4_rst_err", 64'(err_o), 64'd0);
        chk("t4_rst_ovf", 64'(ovf_o), 64'd0);
        rst_i = 1'b0;
        e0 = n_errp; v0 = n_vld;
        shift_bits({64'h0, 64'h0f0f1234abcd9876}, 34);
        repeat (4) tick();
        ss_i = 1'b1;
        repeat (8) tick();
        chk("t4_no_err", 64'(n_errp - e0), 64'd0);
        chk("t4_no_vld", 64'(n_vld - v0), 64'd0);
        expect_frame("t4", 64'hcafef00d12345678);

        // 5: sclk activity while ss is high is ignored
        e0 = n_errp; v0 = n_vld;
        for (int k = 0; k < 20; k++) begin
            sclk_i = 1'b1;
            repeat (4) tick();
            sclk_i = 1'b0;
            repeat (4) tick();
        end
        chk("t5_no_err", 64'(n_errp - e0), 64'd0);
        chk("t5_no_vld", 64'(n_vld - v0), 64'd0);
        expect_frame("t5", 64'h1);

        // 6: delivery on the same cycle as the handshake of the previous frame
        rdy_i = 1'b0;
        expect_frame("t6a", 64'h5555aaaa3333cccc);
        o0 = n_ovfp;
        frame_body({64'h0, 64'h0f1e2d3c4b5a6978}, 64);
        chk("t6_hold_vld", 64'(vld_o), 64'd1);
        chk("t6_hold_data", data_o, 64'h5555aaaa3333cccc);
        ss_i = 1'b1;
        repeat (4) tick();
        chk("t6_pre_data", data_o, 64'h5555aaaa3333cccc);
        rdy_i = 1'b1;
        tick();
        chk("t6_vld", 64'(vld_o), 64'd1);
        chk("t6_data", data_o, 64'h0f1e2d3c4b5a6978);
        chk("t6_ovf", 64'(n_ovfp - o0), 64'd0);
        tick();
        chk("t6_vld_clr", 64'(vld_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_spi_rx.md
Name: sseg_spi_rx

Overview:
- Serial receiver for the display-link framing that sseg produces.
- Oversamples sclk/sdo/ss in the system clock domain and deserializes one WIDTH-bit frame per ss-low window.
- Presents each frame on a valid/ready output.
- Used as the display-side model in simulation and as the receive end on boards that chain display controllers.

Parameters:
- WIDTH, 64, bits per frame; also the output data width.
- SYNC_STAGES, 2, synchronizer flops on each of sclk/sdo/ss (min 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock; idle low; asynchronous to clk.
- sdo  input  1  serial data; MSB first; sampled on sclk rising edge.
- ss  input  1  frame select; active low.
- data  output  WIDTH  received frame; bit WIDTH-1 is the first bit shifted.
- vld  output  1  data holds a complete frame.
- rdy  input  1  consumer accepts data when vld & rdy.
- err  output  1  one-cycle pulse: frame length was not equal to WIDTH.
- ovf  output  1  one-cycle pulse: a good frame was dropped because the output was still occupied.

Behaviour:
- Reset: data=0, vld=0, err=0, ovf=0; bit counter=0; shift register=0; synchronizers load the idle values (sclk=0, sdo=0, ss=1); FSM=WAIT_IDLE.
- Input sampling:
  - Each of sclk/sdo/ss passes through SYNC_STAGES flops.
  - Edge detect uses one extra flop on the synced sclk and synced ss.
  - Input timing requirement: sclk high and low phases each >= 2 clk periods. Faster input is out of spec, with undefined results.
- FSM:
  - WAIT_IDLE: ignore all input until synced ss=1, then IDLE. Prevents capturing a partial frame after reset mid-frame.
  - IDLE: synced ss falling edge -> SHIFT; clear counter and shift register. sclk edges while ss=1 are ignored.
  - SHIFT, on each synced sclk rising edge with ss=0:
    - shift register <= {shift[WIDTH-2:0], sdo_synced};
    - counter += 1, saturating at WIDTH+1. Counter width is clog2(WIDTH+2).
  - SHIFT, on synced ss rising edge -> IDLE:
    - If counter==WIDTH: deliver the frame (see output rules).
    - Otherwise: err=1 for one cycle; output unchanged. This covers a zero-length frame (ss pulse with no sclk).
  - An sclk rising edge in the same cycle as the ss rising edge is ignored; only the ss edge is acted on.
- Output rules:
  - Handshake completes on any cycle with vld & rdy. On that cycle vld clears, unless a new frame is delivered in the same cycle.
  - Deliver with vld=0, or with vld=1 & rdy=1 in the same cycle: data <= shift register, vld=1. The old frame counts as consumed.
  - Deliver with vld=1 & rdy=0: new frame dropped; ovf=1 for one cycle; data and vld unchanged.
  - data is stable whenever vld=1 & rdy=0.
  - rdy is ignored while vld=0.
- Latency: vld rises exactly SYNC_STAGES+2 clk cycles after the ss pin rising edge is first sampled.
- err and ovf are never asserted together. Both are pulses, so both return to 0 on the next cycle.
- rst asserted mid-frame or with vld=1 discards everything and returns to the reset state on the next edge.

Test Plan:
1. Clock WIDTH=64 frame 64'hdeadbeefbeefface (MSB first, sclk period 8 clk), rdy=1 -> vld pulses 1 cycle exactly SYNC_STAGES+2=4 clk after ss rises, data=64'hdeadbeefbeefface, err=0, ovf=0.
2. Hold rdy=0; send 64'h0123456789abcdef, then 64'hffffffff00000000 -> first frame held with vld=1; ovf pulses once at the second ss rise; data stays 64'h0123456789abcdef. Raise rdy -> vld clears the cycle after the handshake.
3. Short frame of 10 bits, then a 65-bit frame, then ss low/high with no sclk -> three err pulses, vld never asserts, data unchanged from the prior value.
4. Assert rst at bit 30 of a frame while ss stays low; release rst -> all outputs 0. The remaining bits and the ss rise produce no err and no vld. The next full frame 64'hcafef00d12345678 is received correctly.
5. sclk toggling 20 times while ss=1, then a valid frame 64'h1 -> ignored edges have no effect; data=64'h1, vld=1.
6. Frame completes on the same cycle rdy handshakes the previous frame (vld=1, rdy=1) -> vld stays 1, data updates to the new frame, ovf=0.
